// File: rtl/dds_phase2amp.sv
// dds_phase2amp: converts the DDS accumulator phase into an offset-binary DAC sample.
// The top ADDR_W phase bits plus a phase offset form the lookup address. The sine is
// built from a quarter-wave ROM with symmetry folding; triangle, sawtooth and square
// are derived directly from the address. The pipeline has four register stages with a
// valid strobe. A waveform request is adopted only at a phase wrap, so a period never
// mixes two shapes.
module dds_phase2amp #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 11,
  parameter int ROM_AW = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       phase_in,
  input  logic              phase_vld,
  input  logic [ADDR_W-1:0] phase_off,
  input  logic [1:0]        wave_sel,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_vld,
  output logic [1:0]        sel_active
);

  typedef enum logic [1:0] {
    WAVE_SINE = 2'd0,
    WAVE_TRI  = 2'd1,
    WAVE_SAW  = 2'd2,
    WAVE_SQR  = 2'd3
  } wave_e;

  localparam int                ROM_DEPTH = 2 ** ROM_AW;
  localparam logic [DATA_W-1:0] MID_HIGH  = DATA_W'(512);
  localparam logic [DATA_W-1:0] MID_LOW   = DATA_W'(511);
  // pi in unsigned Q4.60 fixed point.
  localparam logic signed [127:0] PI_Q60  = 128'sh3243F6A8885A308D;

  // Quarter-wave table entry round(511*sin(pi*(2i+1)/2048)). The Taylor series is
  // evaluated in Q60 at elaboration time, so only the constant table is built.
  function automatic logic [ROM_AW-1:0] rom_entry(input int idx);
    logic signed [127:0] x, x2, term, sum, scaled;
    x    = (PI_Q60 * 128'(2 * idx + 1)) >>> 11;
    x2   = (x * x) >>> 60;
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 60) / 128'(2 * k * (2 * k + 1));
      sum  = sum + term;
    end
    scaled = (sum * 128'sd511 + (128'sd1 <<< 59)) >>> 60;
    return ROM_AW'(scaled);
  endfunction

  logic [ROM_AW-1:0] w_rom [ROM_DEPTH];

  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    localparam logic [ROM_AW-1:0] ENTRY = rom_entry(g);
    assign w_rom[g] = ENTRY;
  end

  logic [ADDR_W-1:0] w_addr;
  logic              w_wrap;
  wave_e             w_sel;
  logic [ROM_AW-1:0] w_fold_idx;
  logic [DATA_W-1:0] w_sample;
  logic              w_unused;

  logic              r_first;
  logic [ADDR_W-1:0] r_prev_addr;
  wave_e             r_sel_active;
  logic              r1_vld, r2_vld, r3_vld, r_dac_vld;
  logic [ADDR_W-1:0] r1_addr, r2_addr, r3_addr;
  wave_e             r1_sel, r2_sel, r3_sel;
  logic [1:0]        r2_q, r3_q;
  logic [ROM_AW-1:0] r2_rom_idx, r3_mag;
  logic [DATA_W-1:0] r_dac_data;

  // Lower phase bits only refine the accumulator; they do not take part in lookup.
  assign w_unused = ^phase_in[31-ADDR_W:0];

  // The address wraps modulo 2^ADDR_W. A smaller address than the last valid one marks
  // a wrap, and the first sample after reset always adopts the request.
  assign w_addr = phase_in[31 -: ADDR_W] + phase_off;
  assign w_wrap = r_first || (w_addr < r_prev_addr);
  assign w_sel  = w_wrap ? wave_e'(wave_sel) : r_sel_active;

  // Odd quadrants read the quarter wave backwards.
  assign w_fold_idx = r1_addr[ROM_AW] ? ~r1_addr[ROM_AW-1:0] : r1_addr[ROM_AW-1:0];

  // Valid strobes, wrap tracking, active selection and the held DAC word.
  // NOTE: sequential state uses non-blocking assignments so every stage sees last cycle's values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first      <= 1'b1;
      r_prev_addr  <= '0;
      r_sel_active <= WAVE_SINE;
      r1_vld       <= 1'b0;
      r2_vld       <= 1'b0;
      r3_vld       <= 1'b0;
      r_dac_vld    <= 1'b0;
      r_dac_data   <= MID_HIGH;
    end else begin
      r1_vld    <= phase_vld;
      r2_vld    <= r1_vld;
      r3_vld    <= r2_vld;
      r_dac_vld <= r3_vld;
      if (phase_vld) begin
        r_first      <= 1'b0;
        r_prev_addr  <= w_addr;
        r_sel_active <= w_sel;
      end
      if (r3_vld) begin
        r_dac_data <= w_sample;
      end
    end
  end

  // Per-sample datapath: capture, fold, ROM read. Each sample carries its own selection.
  // NOTE: these registers have no reset; they are only consumed under a valid bit that is reset.
  always_ff @(posedge clk) begin
    if (phase_vld) begin
      r1_addr <= w_addr;
      r1_sel  <= w_sel;
    end
    if (r1_vld) begin
      r2_q       <= r1_addr[ADDR_W-1 -: 2];
      r2_addr    <= r1_addr;
      r2_sel     <= r1_sel;
      r2_rom_idx <= w_fold_idx;
    end
    if (r2_vld) begin
      r3_mag  <= w_rom[r2_rom_idx];
      r3_q    <= r2_q;
      r3_addr <= r2_addr;
      r3_sel  <= r2_sel;
    end
  end

  // Format the stage-3 sample into offset binary for the selected waveform.
  always_comb begin
    // NOTE: default first so every path assigns w_sample and no latch is inferred.
    w_sample = MID_HIGH;
    unique case (r3_sel)
      WAVE_SINE: w_sample = (r3_q < 2'd2) ? (MID_HIGH + DATA_W'(r3_mag))
                                          : (MID_LOW - DATA_W'(r3_mag));
      WAVE_TRI:  w_sample = r3_addr[ADDR_W-1] ? ~r3_addr[DATA_W-1:0] : r3_addr[DATA_W-1:0];
      WAVE_SAW:  w_sample = r3_addr[ADDR_W-1:1];
      WAVE_SQR:  w_sample = {DATA_W{~r3_addr[ADDR_W-1]}};
    endcase
  end

  assign dac_data   = r_dac_data;
  assign dac_vld    = r_dac_vld;
  assign sel_active = r_sel_active;

endmodule

// File: tb/tb_dds_phase2amp.sv
// Testbench for dds_phase2amp: directed vectors with hand-derived expected samples,
// plus a real-arithmetic sine reference for the full sweep.
module tb_dds_phase2amp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] phase_in = '0;
  logic        phase_vld = 1'b0;
  logic [10:0] phase_off = '0;
  logic [1:0]  wave_sel = '0;
  logic [9:0]  dac_data;
  logic        dac_vld;
  logic [1:0]  sel_active;

  int n_checks = 0;
  int n_errors = 0;
  logic [9:0] got_q[$];

  int wave_a[4]      = '{0, 700, 1024, 1500};
  int wave_exp[3][4] = '{'{0, 700, 1023, 547}, '{0, 350, 512, 750}, '{1023, 1023, 0, 0}};
  int bub_a[4]       = '{100, 900, 900, 300};
  int bub_v[4]       = '{1, 0, 0, 1};
  int bub_s[4]       = '{1, 3, 3, 3};
  int bub_exp_v[4]   = '{1, 0, 0, 1};
  int bub_exp_d[4]   = '{100, 100, 100, 300};

  always #5 clk = ~clk;

  dds_phase2amp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .phase_in   (phase_in),
    .phase_vld  (phase_vld),
    .phase_off  (phase_off),
    .wave_sel   (wave_sel),
    .dac_data   (dac_data),
    .dac_vld    (dac_vld),
    .sel_active (sel_active)
  );

  // Collect every valid output sample in order.
  always @(negedge clk) begin
    if (rst_n && dac_vld) got_q.push_back(dac_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sine_ref(input int a);
    int  q, idx, m;
    real r;
    q   = a / 512;
    idx = (q == 1 || q == 3) ? 511 - (a % 512) : (a % 512);
    r   = 511.0 * $sin(3.141592653589793 * real'(2 * idx + 1) / 2048.0);
    m   = $rtoi(r + 0.5);
    return (q < 2) ? 512 + m : 511 - m;
  endfunction

  task automatic drive(input int a, input int off, input int sel, input logic vld);
    @(negedge clk);
    phase_in  = 32'(a) << 21;
    phase_off = 11'(off);
    wave_sel  = 2'(sel);
    phase_vld = vld;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    phase_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset mid-stream, then latency of the first sample after release.
    do_reset();
    check("rst_vld", 32'(dac_vld), 0);
    check("rst_data", 32'(dac_data), 512);
    for (int i = 0; i < 8; i++) drive(100 + i, 0, 3, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    phase_vld = 1'b0;
    #1;
    check("midrst_vld", 32'(dac_vld), 0);
    check("midrst_data", 32'(dac_data), 512);
    check("midrst_sel", 32'(sel_active), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(700, 0, 2, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) begin
        check("lat_early_vld", 32'(dac_vld), 0);
      end else begin
        check("lat_vld", 32'(dac_vld), 1);
        check("lat_data", 32'(dac_data), 350);
        check("lat_sel", 32'(sel_active), 2);
      end
      phase_vld = 1'b0;
    end

    // Full sine sweep with continuous valid.
    do_reset();
    for (int a = 0; a < 2048; a++) drive(a, 0, 0, 1'b1);
    idle(6);
    check("sweep_count", 32'(got_q.size()), 2048);
    if (got_q.size() == 2048) begin
      check("sine_a0", 32'(got_q[0]), 513);
      check("sine_a511", 32'(got_q[511]), 1023);
      check("sine_a512", 32'(got_q[512]), 1023);
      check("sine_a1024", 32'(got_q[1024]), 510);
      check("sine_a1535", 32'(got_q[1535]), 0);
      check("sine_a2047", 32'(got_q[2047]), 510);
      for (int a = 0; a < 2048; a++) check($sformatf("sine_ref_%0d", a), 32'(got_q[a]), 32'(sine_ref(a)));
      for (int a = 0; a < 1024; a++)
        check($sformatf("sine_antisym_%0d", a), 32'(got_q[a]) + 32'(got_q[a + 1024]), 1023);
    end

    // Triangle, sawtooth and square at selected addresses.
    for (int s = 1; s <= 3; s++) begin
      do_reset();
      for (int i = 0; i < 4; i++) drive(wave_a[i], 0, s, 1'b1);
      idle(6);
      check($sformatf("wave%0d_count", s), 32'(got_q.size()), 4);
      for (int i = 0; i < 4; i++)
        check($sformatf("wave%0d_a%0d", s, wave_a[i]), 32'(got_q[i]), 32'(wave_exp[s-1][i]));
      check($sformatf("wave%0d_sel", s), 32'(sel_active), 32'(s));
    end

    // Offset addition wraps modulo 2048: 2000 + 100 -> 52.
    do_reset();
    drive(2000, 100, 0, 1'b1);
    idle(6);
    check("offset_count", 32'(got_q.size()), 1);
    check("offset_sine", 32'(got_q[0]), 594);

    // Waveform request mid-period is deferred to the next wrap.
    do_reset();
    for (int i = 0; i < 2052; i++) begin
      @(negedge clk);
      if (i == 1000) check("defer_sel_mid", 32'(sel_active), 0);
      if (i == 2048) check("defer_sel_before_wrap", 32'(sel_active), 0);
      if (i == 2049) check("defer_sel_after_wrap", 32'(sel_active), 3);
      phase_in  = 32'(i % 2048) << 21;
      phase_off = '0;
      wave_sel  = (i >= 600) ? 2'd3 : 2'd0;
      phase_vld = 1'b1;
    end
    idle(6);
    check("defer_count", 32'(got_q.size()), 2052);
    check("defer_a599", 32'(got_q[599]), 32'(sine_ref(599)));
    check("defer_a600", 32'(got_q[600]), 32'(sine_ref(600)));
    check("defer_a2047", 32'(got_q[2047]), 510);
    check("defer_wrap_a0", 32'(got_q[2048]), 1023);
    check("defer_wrap_a1", 32'(got_q[2049]), 1023);
    check("defer_wrap_a3", 32'(got_q[2051]), 1023);

    // Bubbles: valid pattern 1,0,0,1 reappears four edges later, data held in the gaps.
    // Invalid cycles carry a high address and a square request that must be ignored.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        check($sformatf("bubble_vld_%0d", k - 4), 32'(dac_vld), 32'(bub_exp_v[k-4]));
        check($sformatf("bubble_data_%0d", k - 4), 32'(dac_data), 32'(bub_exp_d[k-4]));
      end
      if (k < 4) begin
        phase_in  = 32'(bub_a[k]) << 21;
        phase_off = '0;
        wave_sel  = 2'(bub_s[k]);
        phase_vld = (bub_v[k] != 0);
      end else begin
        phase_vld = 1'b0;
      end
    end
    check("bubble_sel", 32'(sel_active), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
